// File: rtl/coherence_bus_ctrl.sv
// -----------------------------------------------------------------------------
// coherence_bus_ctrl
// Snoopy-bus coherence sequencer for NUM_CPU cores. Collects per-cpu
// read_miss / write_miss / invalidate levels, picks one owner round-robin,
// broadcasts its tag on boci, snoops the peers, optionally invalidates
// peer copies, then returns a one-cycle grant with the fill source.
//
// Parameters
//   NUM_CPU   cores on the bus (2..8)
//   TAG_W     block tag width
//   SNOOP_LAT cycles cpu_search is held, found is ORed over all of them (1..4)
//
// Ports
//   clk, rst                   clock, synchronous active-high reset
//   read_miss/write_miss/
//   invalidate [NUM_CPU]       per-cpu request levels
//   bico [NUM_CPU*TAG_W]       per-cpu tag, cpu i at [i*TAG_W +: TAG_W]
//   cpu_search_found [NUM_CPU] per-cpu snoop hit
//   boci [TAG_W]               broadcast tag, held until the next latch
//   cpu_search [NUM_CPU]       snoop strobe to peers
//   grant [NUM_CPU]            one-hot completion pulse
//   cpu_datasel [NUM_CPU]      1 = fill from peer cache, valid with grant
//   invalidate_from_other_cpu  one-cycle invalidate strobe to peers
//   busy                       transaction in progress
//
// Optional build macro COH_PERF_CNT_EN adds saturating 16-bit counters
// rd_cnt, wr_cnt, inv_cnt, snoop_hit_cnt.
//
// state  | meaning
// IDLE   | sample requests, pick owner, latch tag
// SNOOP  | cpu_search to peers for SNOOP_LAT cycles, accumulate hits
// INVAL  | one-cycle invalidate strobe to hitting peers
// GRANT  | one-cycle grant + datasel to owner, advance round-robin
// -----------------------------------------------------------------------------
module coherence_bus_ctrl #(
   parameter int NUM_CPU   = 2,
   parameter int TAG_W     = 11,
   parameter int SNOOP_LAT = 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_CPU-1:0]       read_miss,
   input  logic [NUM_CPU-1:0]       write_miss,
   input  logic [NUM_CPU-1:0]       invalidate,
   input  logic [NUM_CPU*TAG_W-1:0] bico,
   input  logic [NUM_CPU-1:0]       cpu_search_found,
   output logic [TAG_W-1:0]         boci,
   output logic [NUM_CPU-1:0]       cpu_search,
   output logic [NUM_CPU-1:0]       grant,
   output logic [NUM_CPU-1:0]       cpu_datasel,
   output logic [NUM_CPU-1:0]       invalidate_from_other_cpu,
   output logic                     busy
`ifdef COH_PERF_CNT_EN
   ,
   output logic [15:0]              rd_cnt,
   output logic [15:0]              wr_cnt,
   output logic [15:0]              inv_cnt,
   output logic [15:0]              snoop_hit_cnt
`endif
);

   if ((NUM_CPU < 2) || (NUM_CPU > 8) || (SNOOP_LAT < 1) || (SNOOP_LAT > 4)) begin : g_param_err
      $error("coherence_bus_ctrl: NUM_CPU must be 2..8 and SNOOP_LAT 1..4");
   end

   localparam int PTR_W = $clog2(NUM_CPU);
   localparam int CNT_W = (SNOOP_LAT > 1) ? $clog2(SNOOP_LAT) : 1;

   typedef enum logic [1:0] {S_IDLE, S_SNOOP, S_INVAL, S_GRANT} state_t;
   typedef enum logic [1:0] {T_RD, T_WR, T_INV} xact_t;

   state_t             state, state_nx;
   xact_t              xtype, win_type;
   logic [PTR_W-1:0]   rr_ptr, owner, win_idx;
   logic [NUM_CPU-1:0] holdoff, hit_mask, hit_next;
   logic [NUM_CPU-1:0] req, eligible, owner_oh, peer_mask;
   logic [CNT_W-1:0]   snoop_cnt;
   logic               win_found;
   int                 cand;

   assign req       = read_miss | write_miss | invalidate;
   assign eligible  = req & ~holdoff;
   assign owner_oh  = NUM_CPU'(1) << owner;
   assign peer_mask = ~owner_oh;
   // the owner's own found line is masked off here
   assign hit_next  = hit_mask | (cpu_search_found & peer_mask);

   // round-robin search upward from rr_ptr, wrapping at NUM_CPU-1
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      cand      = 0;
      for (int k = 0; k < NUM_CPU; k++) begin
         cand = int'(rr_ptr) + k;
         if (cand >= NUM_CPU) cand = cand - NUM_CPU;
         if (!win_found && eligible[PTR_W'(cand)]) begin
            win_found = 1'b1;
            win_idx   = PTR_W'(cand);
         end
      end
   end

   always_comb begin
      win_type = T_RD;
      if (write_miss[win_idx])      win_type = T_WR;
      else if (invalidate[win_idx]) win_type = T_INV;
   end

   always_comb begin
      state_nx                  = state;
      cpu_search                = '0;
      grant                     = '0;
      cpu_datasel               = '0;
      invalidate_from_other_cpu = '0;
      busy                      = (state != S_IDLE);
      case (state)
         S_IDLE: begin
            if (win_found) state_nx = S_SNOOP;
         end
         S_SNOOP: begin
            cpu_search = peer_mask;
            if (snoop_cnt == '0) begin
               if ((xtype != T_RD) && (|hit_next)) state_nx = S_INVAL;
               else                                state_nx = S_GRANT;
            end
         end
         S_INVAL: begin
            invalidate_from_other_cpu = hit_mask;
            state_nx                  = S_GRANT;
         end
         S_GRANT: begin
            grant = owner_oh;
            if ((xtype != T_INV) && (|hit_mask)) cpu_datasel = owner_oh;
            state_nx = S_IDLE;
         end
         default: state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         rr_ptr    <= '0;
         holdoff   <= '0;
         owner     <= '0;
         xtype     <= T_RD;
         hit_mask  <= '0;
         snoop_cnt <= '0;
         boci      <= '0;
      end else begin
         state <= state_nx;
         case (state)
            S_IDLE: begin
               holdoff  <= '0;
               hit_mask <= '0;
               if (win_found) begin
                  owner     <= win_idx;
                  xtype     <= win_type;
                  boci      <= bico[int'(win_idx)*TAG_W +: TAG_W];
                  snoop_cnt <= CNT_W'(SNOOP_LAT - 1);
               end
            end
            S_SNOOP: begin
               hit_mask <= hit_next;
               if (snoop_cnt != '0) snoop_cnt <= snoop_cnt - 1'b1;
            end
            S_GRANT: begin
               rr_ptr   <= (owner == PTR_W'(NUM_CPU - 1)) ? '0 : owner + PTR_W'(1);
               // masks the owner's stale request level for one IDLE cycle
               holdoff  <= owner_oh;
               hit_mask <= '0;
            end
            default: ;
         endcase
      end
   end

`ifdef COH_PERF_CNT_EN
   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_cnt        <= '0;
         wr_cnt        <= '0;
         inv_cnt       <= '0;
         snoop_hit_cnt <= '0;
      end else if (state == S_GRANT) begin
         case (xtype)
            T_RD:    rd_cnt  <= sat_inc(rd_cnt);
            T_WR:    wr_cnt  <= sat_inc(wr_cnt);
            T_INV:   inv_cnt <= sat_inc(inv_cnt);
            default: ;
         endcase
         if (|hit_mask) snoop_hit_cnt <= sat_inc(snoop_hit_cnt);
      end
   end
`endif

endmodule

// File: tb/tb_coherence_bus_ctrl.sv
// -----------------------------------------------------------------------------
// Bench for coherence_bus_ctrl. Two instances share clock and reset:
//   dut4: NUM_CPU=4, SNOOP_LAT=1 (directed sequences + randomized traffic
//         against a transaction-level reference model)
//   dut2: NUM_CPU=2, SNOOP_LAT=3 (multi-cycle snoop accumulation)
// -----------------------------------------------------------------------------
module tb_coherence_bus_ctrl;

   localparam int N4 = 4;
   localparam int L4 = 1;
   localparam int TW = 11;

   logic clk;
   logic rst;

   logic [N4-1:0]    rm4, wm4, iv4, fd4;
   logic [N4*TW-1:0] bico4;
   logic [TW-1:0]    boci4;
   logic [N4-1:0]    srch4, gnt4, dsel4, inv4;
   logic             busy4;

   logic [1:0]       rm2, wm2, iv2, fd2;
   logic [2*TW-1:0]  bico2;
   logic [TW-1:0]    boci2;
   logic [1:0]       srch2, gnt2, dsel2, inv2;
   logic             busy2;

`ifdef COH_PERF_CNT_EN
   logic [15:0] rdc4, wrc4, ivc4, hitc4, rdc2, wrc2, ivc2, hitc2;
`endif

   coherence_bus_ctrl #(.NUM_CPU(N4), .TAG_W(TW), .SNOOP_LAT(L4)) dut4 (
      .clk(clk), .rst(rst),
      .read_miss(rm4), .write_miss(wm4), .invalidate(iv4),
      .bico(bico4), .cpu_search_found(fd4),
      .boci(boci4), .cpu_search(srch4), .grant(gnt4), .cpu_datasel(dsel4),
      .invalidate_from_other_cpu(inv4), .busy(busy4)
`ifdef COH_PERF_CNT_EN
      , .rd_cnt(rdc4), .wr_cnt(wrc4), .inv_cnt(ivc4), .snoop_hit_cnt(hitc4)
`endif
   );

   coherence_bus_ctrl #(.NUM_CPU(2), .TAG_W(TW), .SNOOP_LAT(3)) dut2 (
      .clk(clk), .rst(rst),
      .read_miss(rm2), .write_miss(wm2), .invalidate(iv2),
      .bico(bico2), .cpu_search_found(fd2),
      .boci(boci2), .cpu_search(srch2), .grant(gnt2), .cpu_datasel(dsel2),
      .invalidate_from_other_cpu(inv2), .busy(busy2)
`ifdef COH_PERF_CNT_EN
      , .rd_cnt(rdc2), .wr_cnt(wrc2), .inv_cnt(ivc2), .snoop_hit_cnt(hitc2)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // requester state for dut4: bits {write_miss, invalidate, read_miss}
   logic [2:0]    p_bits [N4];
   logic [TW-1:0] p_tag  [N4];

   // reference model state
   int            m_rr;
   logic [N4-1:0] m_hold;
   logic [TW-1:0] m_boci;
   int            stale;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk4(input string tag, input logic [3:0] s, input logic [3:0] g,
                       input logic [3:0] d, input logic [3:0] i, input logic b,
                       input logic [TW-1:0] bo);
      chk({tag, "_search"}, 64'(srch4), 64'(s));
      chk({tag, "_grant"},  64'(gnt4),  64'(g));
      chk({tag, "_dsel"},   64'(dsel4), 64'(d));
      chk({tag, "_inval"},  64'(inv4),  64'(i));
      chk({tag, "_busy"},   64'(busy4), 64'(b));
      chk({tag, "_boci"},   64'(boci4), 64'(bo));
   endtask

   task automatic chk2(input string tag, input logic [1:0] s, input logic [1:0] g,
                       input logic [1:0] d, input logic [1:0] i, input logic b,
                       input logic [TW-1:0] bo);
      chk({tag, "_search"}, 64'(srch2), 64'(s));
      chk({tag, "_grant"},  64'(gnt2),  64'(g));
      chk({tag, "_dsel"},   64'(dsel2), 64'(d));
      chk({tag, "_inval"},  64'(inv2),  64'(i));
      chk({tag, "_busy"},   64'(busy2), 64'(b));
      chk({tag, "_boci"},   64'(boci2), 64'(bo));
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive();
      for (int i = 0; i < N4; i++) begin
         wm4[i] = p_bits[i][2];
         iv4[i] = p_bits[i][1];
         rm4[i] = p_bits[i][0];
         bico4[i*TW +: TW] = p_tag[i];
      end
   endtask

   function automatic logic [N4-1:0] req_vec();
      logic [N4-1:0] r;
      for (int i = 0; i < N4; i++) r[i] = |p_bits[i];
      return r;
   endfunction

   task automatic spawn();
      for (int i = 0; i < N4; i++)
         if (p_bits[i] == 3'b000 && $urandom_range(0, 2) == 0) begin
            p_bits[i] = 3'($urandom_range(1, 7));
            p_tag[i]  = TW'($urandom);
         end
   endtask

   task automatic clear_stale();
      if (stale >= 0) begin
         p_bits[stale] = 3'b000;
         stale = -1;
         drive();
      end
   endtask

   task automatic clear_all();
      for (int i = 0; i < N4; i++) begin
         p_bits[i] = 3'b000;
         p_tag[i]  = '0;
      end
      drive();
      fd4 = '0;
   endtask

   // One IDLE cycle of the model; if a request wins, the whole transaction
   // timeline (snoop, optional invalidate, grant) is predicted and checked.
   task automatic idle_step();
      logic [N4-1:0] elig, oh, hit, f, dsel;
      int owner, typ;  // typ: 0 read, 1 write, 2 invalidate
      chk4("rnd_idle", 4'b0, 4'b0, 4'b0, 4'b0, 1'b0, m_boci);
      spawn();
      drive();
      fd4 = 4'($urandom);
      elig   = req_vec() & ~m_hold;
      m_hold = '0;
      owner  = -1;
      for (int k = 0; k < N4; k++)
         if (owner < 0 && elig[(m_rr + k) % N4]) owner = (m_rr + k) % N4;
      if (owner < 0) begin
         tick();
         clear_stale();
         return;
      end
      typ    = p_bits[owner][2] ? 1 : (p_bits[owner][1] ? 2 : 0);
      m_boci = p_tag[owner];
      oh     = 4'(1 << owner);
      hit    = '0;
      tick();
      clear_stale();
      for (int s = 0; s < L4; s++) begin
         chk4("rnd_snoop", ~oh, 4'b0, 4'b0, 4'b0, 1'b1, m_boci);
         spawn();
         drive();
         f   = 4'($urandom);
         fd4 = f;
         hit = hit | (f & ~oh);
         tick();
      end
      if (typ != 0 && hit != 0) begin
         chk4("rnd_inval", 4'b0, 4'b0, 4'b0, hit, 1'b1, m_boci);
         spawn();
         drive();
         fd4 = 4'($urandom);
         tick();
      end
      dsel = (typ != 2 && hit != 0) ? oh : 4'b0;
      chk4("rnd_grant", 4'b0, oh, dsel, 4'b0, 1'b1, m_boci);
      spawn();
      drive();
      fd4 = 4'($urandom);
      tick();
      m_rr   = (owner + 1) % N4;
      m_hold = oh;
      stale  = owner;
   endtask

   initial begin
      rst = 1'b1;
      rm2 = '0; wm2 = '0; iv2 = '0; fd2 = '0; bico2 = '0;
      clear_all();
      tick();
      tick();
      chk4("reset", 4'b0, 4'b0, 4'b0, 4'b0, 1'b0, 11'h0);
      chk2("reset2", 2'b0, 2'b0, 2'b0, 2'b0, 1'b0, 11'h0);
      rst = 1'b0;

      // SNOOP_LAT=3: peer hit only on the 2nd snoop cycle is still recorded
      rm2 = 2'b01; bico2[0 +: TW] = 11'h2AA;
      tick();
      chk2("l3_s1", 2'b10, 2'b00, 2'b00, 2'b00, 1'b1, 11'h2AA);
      tick();
      chk2("l3_s2", 2'b10, 2'b00, 2'b00, 2'b00, 1'b1, 11'h2AA);
      fd2 = 2'b10;
      tick();
      fd2 = 2'b00;
      chk2("l3_s3", 2'b10, 2'b00, 2'b00, 2'b00, 1'b1, 11'h2AA);
      tick();
      chk2("l3_grant", 2'b00, 2'b01, 2'b01, 2'b00, 1'b1, 11'h2AA);
      rm2 = 2'b00;
      tick();
      // owner's own found line must be ignored
      rm2 = 2'b10; bico2[TW +: TW] = 11'h155; fd2 = 2'b10;
      tick();
      chk2("own_s1", 2'b01, 2'b00, 2'b00, 2'b00, 1'b1, 11'h155);
      tick();
      tick();
      tick();
      chk2("own_grant", 2'b00, 2'b10, 2'b00, 2'b00, 1'b1, 11'h155);
      rm2 = 2'b00; fd2 = 2'b00;
      tick();
      chk2("own_idle", 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 11'h155);

      // read_miss, no peer hit
      p_bits[0] = 3'b001; p_tag[0] = 11'h1A5; drive();
      tick();
      chk4("a_snoop", 4'b1110, 4'b0, 4'b0, 4'b0, 1'b1, 11'h1A5);
      tick();
      chk4("a_grant", 4'b0, 4'b0001, 4'b0, 4'b0, 1'b1, 11'h1A5);
      p_bits[0] = 3'b000; drive();
      tick();

      // write_miss with peer hit: invalidate cycle, then grant with peer fill
      p_bits[1] = 3'b100; p_tag[1] = 11'h07F; drive();
      tick();
      chk4("b_snoop", 4'b1101, 4'b0, 4'b0, 4'b0, 1'b1, 11'h07F);
      fd4 = 4'b0001;
      tick();
      fd4 = 4'b0000;
      chk4("b_inval", 4'b0, 4'b0, 4'b0, 4'b0001, 1'b1, 11'h07F);
      tick();
      chk4("b_grant", 4'b0, 4'b0010, 4'b0010, 4'b0, 1'b1, 11'h07F);
      p_bits[1] = 3'b000; drive();
      tick();

      // invalidate with peer hit (plus own found): datasel stays 0
      p_bits[0] = 3'b010; p_tag[0] = 11'h3C3; drive();
      tick();
      chk4("c_snoop", 4'b1110, 4'b0, 4'b0, 4'b0, 1'b1, 11'h3C3);
      fd4 = 4'b0011;
      tick();
      fd4 = 4'b0000;
      chk4("c_inval", 4'b0, 4'b0, 4'b0, 4'b0010, 1'b1, 11'h3C3);
      tick();
      chk4("c_grant", 4'b0, 4'b0001, 4'b0, 4'b0, 1'b1, 11'h3C3);
      p_bits[0] = 3'b000; drive();
      tick();

      // reset mid-snoop aborts; held requests re-run with rr_ptr back at 0
      p_bits[0] = 3'b001; p_tag[0] = 11'h100;
      p_bits[2] = 3'b001; p_tag[2] = 11'h200; drive();
      tick();
      chk4("e_snoop", 4'b1011, 4'b0, 4'b0, 4'b0, 1'b1, 11'h200);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk4("e_rst", 4'b0, 4'b0, 4'b0, 4'b0, 1'b0, 11'h0);
      tick();
      chk4("e_resnoop", 4'b1110, 4'b0, 4'b0, 4'b0, 1'b1, 11'h100);
      tick();
      chk4("e_grant0", 4'b0, 4'b0001, 4'b0, 4'b0, 1'b1, 11'h100);
      p_bits[0] = 3'b000; drive();
      tick();
      chk4("e_idle", 4'b0, 4'b0, 4'b0, 4'b0, 1'b0, 11'h100);
      tick();
      chk4("e_snoop2", 4'b1011, 4'b0, 4'b0, 4'b0, 1'b1, 11'h200);
      tick();
      chk4("e_grant2", 4'b0, 4'b0100, 4'b0, 4'b0, 1'b1, 11'h200);
      p_bits[2] = 3'b000; drive();
      tick();

      // four read_miss held from reset: grants cpu0..cpu3, three cycles apart
      rst = 1'b1;
      clear_all();
      tick();
      rst = 1'b0;
      for (int i = 0; i < N4; i++) begin
         p_bits[i] = 3'b001;
         p_tag[i]  = TW'(11'h010 + i);
      end
      drive();
      for (int c = 2; c <= 13; c++) begin
         tick();
         chk($sformatf("rr_grant_c%0d", c), 64'(gnt4),
             (c % 3 == 0 && c <= 12) ? 64'(1 << (c / 3 - 1)) : 64'd0);
         chk($sformatf("rr_busy_c%0d", c), 64'(busy4), (c % 3 != 1) ? 64'd1 : 64'd0);
         if (c % 3 == 0 && c <= 12) begin
            p_bits[c / 3 - 1] = 3'b000;
            drive();
         end
      end

      // randomized traffic against the reference model
      rst = 1'b1;
      clear_all();
      tick();
      rst = 1'b0;
      m_rr = 0; m_hold = '0; m_boci = '0; stale = -1;
      for (int it = 0; it < 400; it++) idle_step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
